// File: rtl/if_pkg.sv
// ============================================================================
// Module      : if_pkg
// Description : Shared types and constants for the instruction-fetch stage.
//               XLEN        - datapath width
//               IMEM_ALIGN  - instruction size / PC increment in bytes
//               NOP_INSTR   - canonical RV32 NOP (addi x0,x0,0)
//               fetch_entry_t - {pc, instr} pair handed to decode
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package if_pkg;

    localparam int          XLEN       = 32;
    localparam int          IMEM_ALIGN = 4;
    localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

endpackage

`default_nettype wire

// File: rtl/if_fetch_fifo.sv
// ============================================================================
// Module      : if_fetch_fifo
// Description : Circular fetch buffer holding {pc, instr} entries for decode.
//               Head entry is presented combinationally from storage. Push and
//               pop may occur in the same cycle, including when full or empty
//               (no bypass: an entry pushed into an empty buffer is visible
//               one cycle later). Flush empties the buffer in one cycle.
// Ports       : clk, rst           - clock, synchronous active-high reset
//               i_push, i_push_data - write an entry (caller guarantees room)
//               i_pop               - consume the head entry (ignored if empty)
//               i_flush             - discard all entries
//               o_head, o_empty, o_count - head entry, empty flag, occupancy
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module if_fetch_fifo
    import if_pkg::*;
#(
    parameter int FIFO_DEPTH = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        i_push,
    input  fetch_entry_t                i_push_data,
    input  logic                        i_pop,
    input  logic                        i_flush,
    output fetch_entry_t                o_head,
    output logic                        o_empty,
    output logic [$clog2(FIFO_DEPTH):0] o_count
);

    localparam int c_PW = $clog2(FIFO_DEPTH);
    localparam int c_CW = c_PW + 1;

    fetch_entry_t    r_mem [FIFO_DEPTH];
    logic [c_PW-1:0] r_wr_ptr;
    logic [c_PW-1:0] r_rd_ptr;
    logic [c_CW-1:0] r_count;
    logic            w_pop;

    assign w_pop = i_pop && (r_count != '0);

    // Depth is a power of two, so pointer wrap is the natural overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_wr_ptr] <= i_push_data;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= r_count + c_CW'(i_push) - c_CW'(w_pop);
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_empty = (r_count == '0);
    assign o_count = r_count;

endmodule

`default_nettype wire

// File: rtl/if_fetch_stage.sv
// ============================================================================
// Module      : if_fetch_stage
// Description : Instruction-fetch stage. Issues sequential word-aligned
//               fetches starting at basic_addr+4, buffers in-order memory
//               responses and hands {pc, instr} to decode via valid/ready.
//               Redirects flush the buffer and discard in-flight fetches.
// Ports       : CLK, RSTn (synchronous, active-high despite the name)
//               basic_addr                  - reset PC
//               imem_req_valid/addr/ready   - fetch request channel
//               imem_rsp_valid/data         - in-order response, no backpressure
//               redirect_valid/redirect_pc  - branch/jump redirect pulse
//               id_valid/ready/pc/instr     - decode handshake
//               misalign_o                  - sticky misaligned-redirect flag
// Config      : `define IF_MISALIGN_CHK_EN enables misaligned-redirect
//               detection; otherwise redirect_pc[1:0] is forced to 0 and
//               misalign_o is tied low.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module if_fetch_stage
    import if_pkg::*;
#(
    parameter int FIFO_DEPTH      = 2,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic            CLK,
    input  logic            RSTn,
    input  logic [XLEN-1:0] basic_addr,
    output logic            imem_req_valid,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_req_ready,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            id_valid,
    input  logic            id_ready,
    output logic [XLEN-1:0] id_pc,
    output logic [XLEN-1:0] id_instr,
    output logic            misalign_o
);

    localparam int              c_OW         = $clog2(MAX_OUTSTANDING + 1);
    localparam int              c_TW         = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam logic [XLEN-1:0] c_PC_STEP    = XLEN'(IMEM_ALIGN);
    localparam logic [XLEN-1:0] c_ALIGN_MASK = XLEN'(IMEM_ALIGN - 1);

    logic [XLEN-1:0]             r_next_pc;
    logic [c_OW-1:0]             r_outstanding;
    logic [c_OW-1:0]             r_drop_cnt;
    logic [XLEN-1:0]             r_tag [MAX_OUTSTANDING];
    logic [c_TW-1:0]             r_tag_wr;
    logic [c_TW-1:0]             r_tag_rd;

    logic                        w_halt;
    logic [XLEN-1:0]             w_redirect_target;
    logic                        w_credit_ok;
    logic                        w_req_valid;
    logic                        w_accept;
    logic                        w_rsp;
    logic                        w_drop;
    logic                        w_push;
    logic                        w_pop;
    logic                        w_id_valid;
    logic [c_OW-1:0]             w_out_next;
    fetch_entry_t                w_push_entry;
    fetch_entry_t                w_head;
    logic                        w_fifo_empty;
    logic [$clog2(FIFO_DEPTH):0] w_fifo_count;

    function automatic logic [c_TW-1:0] tag_inc(input logic [c_TW-1:0] ptr);
        return (ptr == c_TW'(MAX_OUTSTANDING - 1)) ? '0 : ptr + 1'b1;
    endfunction

    // ------------------------------------------------------------------------
    // Optional misaligned-redirect detection
    // ------------------------------------------------------------------------
`ifdef IF_MISALIGN_CHK_EN
    logic r_misalign;

    always_ff @(posedge CLK) begin
        if (RSTn) begin
            r_misalign <= 1'b0;
        end else if (redirect_valid) begin
            r_misalign <= |(redirect_pc & c_ALIGN_MASK);
        end
    end

    assign w_halt            = r_misalign;
    assign w_redirect_target = redirect_pc;
`else
    assign w_halt            = 1'b0;
    assign w_redirect_target = redirect_pc & ~c_ALIGN_MASK;
`endif

    // ------------------------------------------------------------------------
    // Issue: every accepted request reserves a buffer slot (outstanding +
    // occupancy below depth), so a response can always be pushed.
    // ------------------------------------------------------------------------
    assign w_credit_ok = (int'(r_outstanding) + int'(w_fifo_count)) < FIFO_DEPTH;
    assign w_req_valid = !RSTn && !redirect_valid && !w_halt
                         && (r_outstanding < c_OW'(MAX_OUTSTANDING)) && w_credit_ok;
    assign w_accept    = w_req_valid && imem_req_ready;

    // ------------------------------------------------------------------------
    // Response: stale responses (older than the last redirect, or arriving in
    // the redirect cycle itself) are discarded.
    // ------------------------------------------------------------------------
    assign w_rsp        = !RSTn && imem_rsp_valid && (r_outstanding != '0);
    assign w_drop       = w_rsp && ((r_drop_cnt != '0) || redirect_valid);
    assign w_push       = w_rsp && !w_drop;
    assign w_out_next   = r_outstanding + c_OW'(w_accept) - c_OW'(w_rsp);
    assign w_push_entry = '{pc: r_tag[r_tag_rd], instr: imem_rsp_data};

    // A pop in the redirect cycle is visible to decode but the flush makes it
    // irrelevant internally.
    assign w_id_valid = !RSTn && !w_fifo_empty && !w_halt;
    assign w_pop      = w_id_valid && id_ready && !redirect_valid;

    always_ff @(posedge CLK) begin
        if (RSTn) begin
            r_next_pc     <= basic_addr + c_PC_STEP;
            r_outstanding <= '0;
            r_drop_cnt    <= '0;
            r_tag_wr      <= '0;
            r_tag_rd      <= '0;
        end else begin
            r_outstanding <= w_out_next;
            if (w_accept) begin
                r_tag[r_tag_wr] <= r_next_pc;
                r_tag_wr        <= tag_inc(r_tag_wr);
            end
            if (w_rsp) begin
                r_tag_rd <= tag_inc(r_tag_rd);
            end
            if (redirect_valid) begin
                // Everything still in flight after this cycle is stale.
                r_next_pc  <= w_redirect_target;
                r_drop_cnt <= w_out_next;
            end else begin
                if (w_accept) begin
                    r_next_pc <= r_next_pc + c_PC_STEP;
                end
                if (w_rsp && (r_drop_cnt != '0)) begin
                    r_drop_cnt <= r_drop_cnt - 1'b1;
                end
            end
        end
    end

    if_fetch_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (CLK),
        .rst         (RSTn),
        .i_push      (w_push),
        .i_push_data (w_push_entry),
        .i_pop       (w_pop),
        .i_flush     (redirect_valid),
        .o_head      (w_head),
        .o_empty     (w_fifo_empty),
        .o_count     (w_fifo_count)
    );

    // All outputs read zero while reset is asserted.
    assign imem_req_valid = w_req_valid;
    assign imem_req_addr  = RSTn ? '0 : r_next_pc;
    assign id_valid       = w_id_valid;
    assign id_pc          = RSTn ? '0 : w_head.pc;
    assign id_instr       = RSTn ? '0 : w_head.instr;
    assign misalign_o     = !RSTn && w_halt;

endmodule

`default_nettype wire

// File: tb/tb_if_fetch_stage.sv
// ============================================================================
// Module      : tb_if_fetch_stage
// Description : Directed self-checking bench for if_fetch_stage with a
//               fixed-latency in-order instruction memory model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_if_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] basic_addr;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_pc;
    logic [31:0] id_instr;
    logic        misalign_o;

    int n_checks = 0;
    int n_pass   = 0;

    int unsigned edge_cnt = 0;
    int          lat      = 1;
    logic [31:0] q_addr[$];
    int unsigned q_due[$];
    logic [31:0] iss[$];
    logic [31:0] got_pc[$];
    logic [31:0] got_instr[$];

    always #5 clk = ~clk;

    if_fetch_stage #(
        .FIFO_DEPTH      (2),
        .MAX_OUTSTANDING (2)
    ) dut (
        .CLK            (clk),
        .RSTn           (rst),
        .basic_addr     (basic_addr),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_pc          (id_pc),
        .id_instr       (id_instr),
        .misalign_o     (misalign_o)
    );

    function automatic logic [31:0] mem_f(input logic [31:0] a);
        return a ^ 32'h5A5A_0013;
    endfunction

    // Request acceptance, decode pops, and memory scheduling at the active edge.
    always @(posedge clk) begin
        if (rst) begin
            q_addr.delete(); q_due.delete(); iss.delete();
            got_pc.delete(); got_instr.delete();
        end else begin
            if (imem_req_valid && imem_req_ready) begin
                q_addr.push_back(imem_req_addr);
                q_due.push_back(edge_cnt + lat);
                iss.push_back(imem_req_addr);
            end
            if (id_valid && id_ready) begin
                got_pc.push_back(id_pc);
                got_instr.push_back(id_instr);
            end
        end
        edge_cnt <= edge_cnt + 1;
    end

    // Present the response due at the coming edge.
    always @(negedge clk) begin
        if (rst) begin
            imem_rsp_valid <= 1'b0;
            imem_rsp_data  <= '0;
        end else if (q_due.size() != 0 && q_due[0] == edge_cnt) begin
            imem_rsp_valid <= 1'b1;
            imem_rsp_data  <= mem_f(q_addr[0]);
            q_due.pop_front();
            q_addr.pop_front();
        end else begin
            imem_rsp_valid <= 1'b0;
            imem_rsp_data  <= '0;
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset(input logic [31:0] base);
        tick();
        rst = 1'b1; basic_addr = base; redirect_valid = 1'b0; redirect_pc = '0;
        imem_req_ready = 1'b1; id_ready = 1'b1;
        run(2);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        tick();
        rst = 1'b1; basic_addr = 32'h003f_fffc; redirect_valid = 1'b0; redirect_pc = '0;
        imem_req_ready = 1'b1; id_ready = 1'b0; lat = 1;
        run(2);
        n_checks++; if (imem_req_valid !== 1'b0) $display("FAIL reset_req_valid got=%b exp=0", imem_req_valid); else n_pass++;
        n_checks++; if (imem_req_addr !== 32'h0) $display("FAIL reset_req_addr got=%h exp=0", imem_req_addr); else n_pass++;
        n_checks++; if (id_valid !== 1'b0) $display("FAIL reset_id_valid got=%b exp=0", id_valid); else n_pass++;
        n_checks++; if (id_pc !== 32'h0) $display("FAIL reset_id_pc got=%h exp=0", id_pc); else n_pass++;
        n_checks++; if (id_instr !== 32'h0) $display("FAIL reset_id_instr got=%h exp=0", id_instr); else n_pass++;
        n_checks++; if (misalign_o !== 1'b0) $display("FAIL reset_misalign got=%b exp=0", misalign_o); else n_pass++;
        rst = 1'b0;
        #1;
        n_checks++; if (imem_req_valid !== 1'b1) $display("FAIL first_req_valid got=%b exp=1", imem_req_valid); else n_pass++;
        n_checks++; if (imem_req_addr !== 32'h0040_0000) $display("FAIL first_req_addr got=%h exp=00400000", imem_req_addr); else n_pass++;
        id_ready = 1'b1;
    endtask

    task automatic test_sequential();
        run(40);
        n_checks++;
        if (got_pc.size() < 8 || iss.size() < 8) begin
            $display("FAIL seq_count got=%0d/%0d exp>=8", got_pc.size(), iss.size());
        end else begin
            n_pass++;
            for (int i = 0; i < 8; i++) begin
                n_checks++; if (iss[i] !== 32'h0040_0000 + 32'(4*i)) $display("FAIL seq_req_addr[%0d] got=%h exp=%h", i, iss[i], 32'h0040_0000 + 32'(4*i)); else n_pass++;
                n_checks++; if (got_pc[i] !== 32'h0040_0000 + 32'(4*i)) $display("FAIL seq_id_pc[%0d] got=%h exp=%h", i, got_pc[i], 32'h0040_0000 + 32'(4*i)); else n_pass++;
                n_checks++; if (got_instr[i] !== mem_f(32'h0040_0000 + 32'(4*i))) $display("FAIL seq_id_instr[%0d] got=%h exp=%h", i, got_instr[i], mem_f(32'h0040_0000 + 32'(4*i))); else n_pass++;
            end
        end
    endtask

    task automatic test_backpressure();
        int          n0;
        logic [31:0] exp_pc;
        id_ready = 1'b0;
        n0     = got_pc.size();
        exp_pc = 32'h0040_0000 + 32'(4*n0);
        for (int i = 1; i <= 6; i++) begin
            tick();
            if (i >= 3) begin
                n_checks++; if (id_valid !== 1'b1) $display("FAIL stall_id_valid[%0d] got=%b exp=1", i, id_valid); else n_pass++;
                n_checks++; if (id_pc !== exp_pc) $display("FAIL stall_id_pc[%0d] got=%h exp=%h", i, id_pc, exp_pc); else n_pass++;
                n_checks++; if (id_instr !== mem_f(exp_pc)) $display("FAIL stall_id_instr[%0d] got=%h exp=%h", i, id_instr, mem_f(exp_pc)); else n_pass++;
                n_checks++; if (imem_req_valid !== 1'b0) $display("FAIL stall_req_valid[%0d] got=%b exp=0", i, imem_req_valid); else n_pass++;
            end
        end
        n_checks++; if (got_pc.size() != n0) $display("FAIL stall_no_pop got=%0d exp=%0d", got_pc.size(), n0); else n_pass++;
        id_ready = 1'b1;
        run(20);
        n_checks++; if (got_pc.size() < n0 + 6) $display("FAIL resume_count got=%0d exp>=%0d", got_pc.size(), n0 + 6); else n_pass++;
        for (int i = 0; i < got_pc.size(); i++) begin
            n_checks++;
            if (got_pc[i] !== 32'h0040_0000 + 32'(4*i) || got_instr[i] !== mem_f(32'h0040_0000 + 32'(4*i)))
                $display("FAIL resume_seq[%0d] got=%h/%h exp=%h", i, got_pc[i], got_instr[i], 32'h0040_0000 + 32'(4*i));
            else n_pass++;
        end
    endtask

    task automatic test_redirect_drop();
        lat = 3;
        do_reset(32'h003f_fffc);
        run(2);
        n_checks++; if (imem_req_valid !== 1'b0) $display("FAIL lat3_outstanding_limit got=%b exp=0", imem_req_valid); else n_pass++;
        redirect_valid = 1'b1; redirect_pc = 32'h0040_0100;
        tick();
        redirect_valid = 1'b0;
        run(20);
        n_checks++;
        if (iss.size() < 3 || got_pc.size() < 3) begin
            $display("FAIL drop_count got=%0d/%0d exp>=3", iss.size(), got_pc.size());
        end else begin
            n_pass++;
            n_checks++; if (iss[2] !== 32'h0040_0100) $display("FAIL drop_req_addr got=%h exp=00400100", iss[2]); else n_pass++;
            for (int i = 0; i < 3; i++) begin
                n_checks++;
                if (got_pc[i] !== 32'h0040_0100 + 32'(4*i) || got_instr[i] !== mem_f(32'h0040_0100 + 32'(4*i)))
                    $display("FAIL drop_id[%0d] got=%h/%h exp=%h", i, got_pc[i], got_instr[i], 32'h0040_0100 + 32'(4*i));
                else n_pass++;
            end
        end
        lat = 1;
    endtask

    task automatic test_redirect_coincident();
        bit          found = 1'b0;
        int          pre;
        logic [31:0] exp_head;
        lat = 1;
        do_reset(32'h003f_fffc);
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            if (imem_rsp_valid && id_valid) found = 1'b1;
        end
        n_checks++;
        if (!found) begin
            $display("FAIL coincide_setup got=timeout exp=rsp_and_id_valid");
        end else begin
            n_pass++;
            pre      = got_pc.size();
            exp_head = 32'h0040_0000 + 32'(4*pre);
            redirect_valid = 1'b1; redirect_pc = 32'h0050_0000;
            tick();
            redirect_valid = 1'b0;
            n_checks++; if (id_valid !== 1'b0) $display("FAIL coincide_id_valid got=%b exp=0", id_valid); else n_pass++;
            n_checks++; if (imem_req_addr !== 32'h0050_0000) $display("FAIL coincide_req_addr got=%h exp=00500000", imem_req_addr); else n_pass++;
            run(10);
            n_checks++;
            if (got_pc.size() < pre + 2) $display("FAIL coincide_count got=%0d exp>=%0d", got_pc.size(), pre + 2);
            else begin
                n_pass++;
                n_checks++; if (got_pc[pre] !== exp_head) $display("FAIL coincide_pop_pc got=%h exp=%h", got_pc[pre], exp_head); else n_pass++;
                n_checks++; if (got_pc[pre+1] !== 32'h0050_0000) $display("FAIL coincide_next_pc got=%h exp=00500000", got_pc[pre+1]); else n_pass++;
            end
        end
    endtask

    task automatic test_wrap();
        lat = 1;
        do_reset(32'hFFFF_FFF8);
        run(10);
        n_checks++;
        if (iss.size() < 2 || got_pc.size() < 2) $display("FAIL wrap_count got=%0d/%0d exp>=2", iss.size(), got_pc.size());
        else begin
            n_pass++;
            n_checks++; if (iss[0] !== 32'hFFFF_FFFC) $display("FAIL wrap_req0 got=%h exp=fffffffc", iss[0]); else n_pass++;
            n_checks++; if (iss[1] !== 32'h0000_0000) $display("FAIL wrap_req1 got=%h exp=00000000", iss[1]); else n_pass++;
            n_checks++; if (got_pc[1] !== 32'h0 || got_instr[1] !== mem_f(32'h0)) $display("FAIL wrap_id1 got=%h/%h exp=00000000", got_pc[1], got_instr[1]); else n_pass++;
        end
    endtask

    task automatic test_misalign();
        int pre;
        lat = 1;
        do_reset(32'h003f_fffc);
        run(5);
        redirect_valid = 1'b1; redirect_pc = 32'h0040_0002;
        tick();
        redirect_valid = 1'b0;
`ifdef IF_MISALIGN_CHK_EN
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (misalign_o !== 1'b1) $display("FAIL misalign_flag[%0d] got=%b exp=1", i, misalign_o); else n_pass++;
            n_checks++; if (imem_req_valid !== 1'b0) $display("FAIL misalign_req_valid[%0d] got=%b exp=0", i, imem_req_valid); else n_pass++;
            n_checks++; if (id_valid !== 1'b0) $display("FAIL misalign_id_valid[%0d] got=%b exp=0", i, id_valid); else n_pass++;
            tick();
        end
        redirect_valid = 1'b1; redirect_pc = 32'h0040_0200;
        tick();
        redirect_valid = 1'b0;
        n_checks++; if (misalign_o !== 1'b0) $display("FAIL misalign_clear got=%b exp=0", misalign_o); else n_pass++;
        n_checks++; if (imem_req_addr !== 32'h0040_0200) $display("FAIL misalign_next_addr got=%h exp=00400200", imem_req_addr); else n_pass++;
        pre = got_pc.size();
        run(10);
        n_checks++; if (got_pc.size() <= pre || got_pc[pre] !== 32'h0040_0200) $display("FAIL misalign_resume_pc got_n=%0d exp=00400200", got_pc.size()); else n_pass++;
`else
        n_checks++; if (misalign_o !== 1'b0) $display("FAIL align_flag got=%b exp=0", misalign_o); else n_pass++;
        n_checks++; if (imem_req_addr !== 32'h0040_0000) $display("FAIL align_req_addr got=%h exp=00400000", imem_req_addr); else n_pass++;
        pre = got_pc.size();
        run(10);
        n_checks++; if (got_pc.size() <= pre || got_pc[pre] !== 32'h0040_0000) $display("FAIL align_id_pc got_n=%0d exp=00400000", got_pc.size()); else n_pass++;
`endif
    endtask

    task automatic test_reset_midstream();
        lat = 1;
        do_reset(32'h003f_fffc);
        run(8);
        rst = 1'b1; basic_addr = 32'h0000_1000;
        tick();
        n_checks++;
        if (imem_req_valid !== 1'b0 || imem_req_addr !== 32'h0 || id_valid !== 1'b0 || id_pc !== 32'h0 || id_instr !== 32'h0 || misalign_o !== 1'b0)
            $display("FAIL midreset_outputs got=%b/%h/%b/%h/%h/%b exp=all_zero", imem_req_valid, imem_req_addr, id_valid, id_pc, id_instr, misalign_o);
        else n_pass++;
        rst = 1'b0;
        run(10);
        n_checks++;
        if (iss.size() < 2 || got_pc.size() < 2) $display("FAIL midreset_count got=%0d/%0d exp>=2", iss.size(), got_pc.size());
        else begin
            n_pass++;
            n_checks++; if (iss[0] !== 32'h0000_1004) $display("FAIL midreset_req0 got=%h exp=00001004", iss[0]); else n_pass++;
            n_checks++; if (got_pc[0] !== 32'h0000_1004) $display("FAIL midreset_id0 got=%h exp=00001004", got_pc[0]); else n_pass++;
            n_checks++; if (got_pc[1] !== 32'h0000_1008) $display("FAIL midreset_id1 got=%h exp=00001008", got_pc[1]); else n_pass++;
        end
    endtask

    initial begin
        rst = 1'b1; basic_addr = '0; imem_req_ready = 1'b1;
        redirect_valid = 1'b0; redirect_pc = '0; id_ready = 1'b0;
        test_reset();
        test_sequential();
        test_backpressure();
        test_redirect_drop();
        test_redirect_coincident();
        test_wrap();
        test_misalign();
        test_reset_midstream();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
